sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 3, which sets the parallel word width in bits (WIDTH >= 2).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-004 Port clr, input, 1 bit, SHALL be a synchronous clear of the partial word, bit counter and ovr.
REQ-005 Port shift, input, 1 bit, SHALL be the bit strobe; si is sampled only when it is high.
REQ-006 Port si, input, 1 bit, SHALL be the serial data in, MSB first.
REQ-007 Port ack, input, 1 bit, SHALL be the consumer's accept of the held word.
REQ-008 Port pout, output, WIDTH bits, SHALL carry the last completed parallel word.
REQ-009 Port valid, output, 1 bit, SHALL indicate that pout holds an unaccepted word.
REQ-010 Port busy, output, 1 bit, SHALL be high while a partial word is in progress (bit count != 0).
REQ-011 Port ovr, output, 1 bit, SHALL be a sticky overrun flag.

Function
REQ-012 The shift register SHALL shift left on each clock edge with shift=1, inserting si at bit 0.
- The first bit received ends in pout[WIDTH-1].
REQ-013 The bit counter SHALL count 0..WIDTH-1, increment on each sampled bit, and wrap to 0 on the bit that completes a word.
REQ-014 Word completion SHALL be the edge that samples shift=1 with count=WIDTH-1.
- The new word appears on pout with valid=1 at that same edge (zero extra latency).
REQ-015 The output buffer SHALL be one deep, with states EMPTY (valid=0) and FULL (valid=1).
- EMPTY->FULL on completion.
- FULL->EMPTY on ack with no completion.
- FULL->FULL on completion together with ack.
REQ-016 In FULL, completion together with ack SHALL load the new word, keep valid=1, and leave ovr unchanged.
REQ-017 In FULL, completion without ack SHALL discard the new word, leave pout unchanged, set ovr=1 and wrap the counter to 0.
REQ-018 ack while EMPTY SHALL be ignored.
REQ-019 pout SHALL hold its value after ack; only valid drops.
REQ-020 clr=1 SHALL zero the counter, the partial shift register and ovr at the next edge, and SHALL take priority over a simultaneous shift (that bit is discarded).
REQ-021 clr SHALL NOT affect pout or valid; ack in the same cycle as clr SHALL still be honoured.
REQ-022 ovr SHALL clear only via rst or clr.
REQ-023 busy SHALL be combinational from the counter (count != 0).

Reset
REQ-024 rst=0 SHALL immediately, without a clock, force pout=0, valid=0, ovr=0, counter=0 and the shift register to 0, so busy=0.
REQ-025 rst asserted mid-word SHALL abandon the partial word; reception SHALL restart at bit 0 on the first shift after rst returns high.

Structure
REQ-026 A shared package SHALL hold the WIDTH default constant and the counter-width constant, $clog2(WIDTH).
REQ-027 The shift register and bit counter SHALL be a sub-module sipo_core, which outputs the partial word, the count and a done pulse.
- sipo_rx adds the output buffer, handshake and ovr logic.

Verification (WIDTH=3)
REQ-028 Reset test: drive rst=0 with no clock edge -> pout=000, valid=0, ovr=0, busy=0.
REQ-029 Basic word test: shift bits 1,0,1 on consecutive cycles -> busy=1 after bit 1; after bit 3, pout=101, valid=1, busy=0; ack one cycle -> valid=0, pout=101.
REQ-030 Overrun test: receive 101 with no ack, then receive 011 -> pout=101, valid=1, ovr=1; then clr -> ovr=0, valid=1.
REQ-031 Simultaneous ack test: hold 101 with valid=1, then send 110 with ack=1 on its third bit -> pout=110, valid=1, ovr=0.
REQ-032 Mid-word clear test: shift 1,1, then clr with shift=1 and si=1, then shift 0,0,1 -> pout=001, valid=1.
REQ-033 Mid-word reset test: shift 1, then pulse rst low asynchronously between edges -> busy=0 at once; shift 1,1,0 -> pout=110.

Source files
------------

// File: rtl/sipo_rx_pkg.sv
// Shared constants and types for the serial-in/parallel-out receiver.
package sipo_rx_pkg;

  localparam int WIDTH_DEFAULT = 3;
  localparam int CNT_W_DEFAULT = $clog2(WIDTH_DEFAULT);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic int cntWidth(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_core.sv
// Bit assembler: MSB-first shift register plus bit counter, flags the bit that completes a word.
module sipo_core
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  localparam int CW = cntWidth(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_si,
  output logic [WIDTH-1:0] o_word,
  output logic [CW-1:0]    o_count,
  output logic             o_done
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Only WIDTH-1 bits need storing: the final bit is taken live from si on the completing edge.
  logic [WIDTH-2:0] r_shreg;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_assembled;
  logic             w_lastBit;

  assign w_assembled = {r_shreg, i_si};
  assign w_lastBit   = (r_count == LAST);

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_shreg <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_shreg <= '0;
      r_count <= '0;
    end else if (i_shift) begin
      r_shreg <= w_assembled[WIDTH-2:0];
      r_count <= w_lastBit ? '0 : r_count + 1'b1;
    end
  end

  assign o_word  = w_assembled;
  assign o_count = r_count;
  assign o_done  = i_shift & ~i_clr & w_lastBit;

endmodule

// File: rtl/sipo_rx.sv
// Serial receiver top: one-deep output buffer with ack handshake and sticky overrun flag.
module sipo_rx
  import sipo_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             si,
  input  logic             ack,
  output logic [WIDTH-1:0] pout,
  output logic             valid,
  output logic             busy,
  output logic             ovr
);

  localparam int CW = cntWidth(WIDTH);

  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    w_count;
  logic             w_done;
  logic             w_load;
  logic             w_setOvr;
  buf_state_e       w_nextState;

  buf_state_e       r_state;
  logic [WIDTH-1:0] r_pout;
  logic             r_ovr;

  sipo_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_clk  (clk),
    .i_rstN (rst),
    .i_clr  (clr),
    .i_shift(shift),
    .i_si   (si),
    .o_word (w_word),
    .o_count(w_count),
    .o_done (w_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= BUF_EMPTY;
      r_pout  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_load) r_pout <= w_word;
      if (clr) r_ovr <= 1'b0;
      else if (w_setOvr) r_ovr <= 1'b1;
    end
  end

  // A completed word arriving while full is only accepted if the consumer drains the buffer on that same edge.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_setOvr    = 1'b0;
    case (r_state)
      BUF_EMPTY: begin
        if (w_done) begin
          w_nextState = BUF_FULL;
          w_load      = 1'b1;
        end
      end
      BUF_FULL: begin
        if (w_done && ack) begin
          w_load = 1'b1;
        end else if (w_done) begin
          w_setOvr = 1'b1;
        end else if (ack) begin
          w_nextState = BUF_EMPTY;
        end
      end
      default: w_nextState = BUF_EMPTY;
    endcase
  end

  assign pout  = r_pout;
  assign valid = (r_state == BUF_FULL);
  assign busy  = (w_count != '0);
  assign ovr   = r_ovr;

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx (WIDTH=3): directed vector table, async-reset sequences, random scoreboard run.
module tb_sipo_rx;

  logic       clk;
  logic       rst = 1'b1;
  logic       clr;
  logic       shift;
  logic       si;
  logic       ack;
  logic [2:0] pout;
  logic       valid;
  logic       busy;
  logic       ovr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       clr;
    logic       shift;
    logic       si;
    logic       ack;
    logic [2:0] expPout;
    logic       expValid;
    logic       expBusy;
    logic       expOvr;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] expQ[$];

  sipo_rx #(.WIDTH(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .shift(shift),
    .si   (si),
    .ack  (ack),
    .pout (pout),
    .valid(valid),
    .busy (busy),
    .ovr  (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic c, input logic s, input logic d, input logic a,
                                 input logic [2:0] p, input logic v, input logic b, input logic o);
    vec_t r;
    r.clr = c; r.shift = s; r.si = d; r.ack = a;
    r.expPout = p; r.expValid = v; r.expBusy = b; r.expOvr = o;
    return r;
  endfunction

  task automatic applyStimulus(input logic c, input logic s, input logic d, input logic a);
    @(negedge clk);
    clr = c; shift = s; si = d; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int mCnt;
    logic [2:0] mShreg;
    logic [2:0] mPout;
    logic [2:0] word;
    logic mFull, mOvr, loaded, c, s, d, a;

    clr = 1'b0; shift = 1'b0; si = 1'b0; ack = 1'b0;

    // Reset must act with no clock edge.
    #1 rst = 1'b0;
    #2;
    checkOutput("reset_pout", pout, 3'b000);
    checkOutput("reset_valid", valid, 1'b0);
    checkOutput("reset_ovr", ovr, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    @(negedge clk) rst = 1'b1;

    vecs.push_back(mkVec(0,1,1,0, 3'b000,0,1,0));
    vecs.push_back(mkVec(0,1,0,0, 3'b000,0,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b101,1,0,0));
    vecs.push_back(mkVec(0,0,0,1, 3'b101,0,0,0));
    vecs.push_back(mkVec(0,0,0,1, 3'b101,0,0,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b101,0,1,0));
    vecs.push_back(mkVec(0,1,0,0, 3'b101,0,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b101,1,0,0));
    vecs.push_back(mkVec(0,1,0,0, 3'b101,1,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b101,1,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b101,1,0,1));
    vecs.push_back(mkVec(1,0,0,0, 3'b101,1,0,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b101,1,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b101,1,1,0));
    vecs.push_back(mkVec(0,1,0,1, 3'b110,1,0,0));
    vecs.push_back(mkVec(0,0,0,1, 3'b110,0,0,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b110,0,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b110,0,1,0));
    vecs.push_back(mkVec(1,1,1,0, 3'b110,0,0,0));
    vecs.push_back(mkVec(0,1,0,0, 3'b110,0,1,0));
    vecs.push_back(mkVec(0,1,0,0, 3'b110,0,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b001,1,0,0));
    vecs.push_back(mkVec(1,0,0,1, 3'b001,0,0,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b001,0,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b001,0,1,0));
    vecs.push_back(mkVec(0,1,1,0, 3'b111,1,0,0));
    vecs.push_back(mkVec(0,1,0,0, 3'b111,1,1,0));
    vecs.push_back(mkVec(0,1,0,0, 3'b111,1,1,0));
    vecs.push_back(mkVec(0,1,0,0, 3'b111,1,0,1));
    vecs.push_back(mkVec(0,0,0,1, 3'b111,0,0,1));
    vecs.push_back(mkVec(0,1,0,0, 3'b111,0,1,1));
    vecs.push_back(mkVec(0,1,1,0, 3'b111,0,1,1));
    vecs.push_back(mkVec(0,1,0,0, 3'b010,1,0,1));
    vecs.push_back(mkVec(1,0,0,1, 3'b010,0,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].clr, vecs[i].shift, vecs[i].si, vecs[i].ack);
      checkOutput($sformatf("vec%0d_pout", i), pout, vecs[i].expPout);
      checkOutput($sformatf("vec%0d_valid", i), valid, vecs[i].expValid);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d_ovr", i), ovr, vecs[i].expOvr);
    end

    // Mid-word asynchronous reset abandons the partial word.
    applyStimulus(0, 1, 1, 0);
    checkOutput("midrst_busy_before", busy, 1'b1);
    @(negedge clk);
    shift = 1'b0; ack = 1'b0; clr = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_pout", pout, 3'b000);
    checkOutput("midrst_valid", valid, 1'b0);
    checkOutput("midrst_ovr", ovr, 1'b0);
    #1 rst = 1'b1;
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("midrst_word_pout", pout, 3'b110);
    checkOutput("midrst_word_valid", valid, 1'b1);

    // Random run against a behavioural model; completed words go through a scoreboard queue.
    @(negedge clk);
    shift = 1'b0; ack = 1'b0; clr = 1'b0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    mCnt = 0; mShreg = '0; mPout = '0; mFull = 1'b0; mOvr = 1'b0;
    for (int n = 0; n < 300; n++) begin
      c = ($urandom_range(0, 15) == 0);
      s = ($urandom_range(0, 3) != 0);
      d = $urandom_range(0, 1);
      a = ($urandom_range(0, 3) == 0);
      loaded = 1'b0;
      if (c) begin
        if (a) mFull = 1'b0;
        mCnt = 0; mShreg = '0; mOvr = 1'b0;
      end else begin
        word = {mShreg[1:0], d};
        if (s && mCnt == 2) begin
          mShreg = word;
          mCnt = 0;
          if (!mFull || a) begin
            mPout = word;
            mFull = 1'b1;
            expQ.push_back(word);
            loaded = 1'b1;
          end else begin
            mOvr = 1'b1;
          end
        end else begin
          if (s) begin
            mShreg = word;
            mCnt = mCnt + 1;
          end
          if (a) mFull = 1'b0;
        end
      end
      applyStimulus(c, s, d, a);
      if (loaded) checkOutput($sformatf("sb%0d_word", n), pout, expQ.pop_front());
      checkOutput($sformatf("sb%0d_valid", n), valid, mFull);
      checkOutput($sformatf("sb%0d_ovr", n), ovr, mOvr);
      checkOutput($sformatf("sb%0d_busy", n), busy, (mCnt != 0));
    end
    checkOutput("sb_final_pout", pout, mPout);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
